flash_loader: RTL

// Boot-time program loader: the write side of the CPU's flash port (flash_en/flash_addr/flash_data).

---
 rtl/flash_loader.sv | 77 +++++++
 1 files changed

// File: rtl/flash_loader.sv
// flash_loader: boot loader turning a byte stream into little-endian word writes on the flash port,
// holding the CPU in reset until the whole image has been written.
module flash_loader #(
   parameter int              WIDTH     = 32,
   parameter logic [WIDTH-1:0] BASE_ADDR = 32'h0,
   parameter int              MAX_WORDS = 1024
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             rx_valid,
   input  logic [7:0]       rx_data,
   output logic             rx_ready,
   input  logic             start,
   output logic             flash_en,
   output logic [WIDTH-1:0] flash_addr,
   output logic [WIDTH-1:0] flash_data,
   output logic             cpu_hold,
   output logic             done,
   output logic             err
);
   typedef enum logic [2:0] {LEN, DATA, WRITE, DONE, ERROR} state_t;
   state_t           state, state_n;
   logic [1:0]       byte_cnt;
   logic [23:0]      sr;
   logic [WIDTH-1:0] words_left, full;
   logic             xfer, last, rearm;
   assign rx_ready = rst & (state == LEN || state == DATA);
   assign xfer     = rx_valid & rx_ready;
   assign last     = xfer & (byte_cnt == 2'd3);
   assign full     = {rx_data, sr};
   assign rearm    = start & (state == DONE || state == ERROR);
   always_comb begin
      state_n = state;
      case (state)
         LEN:     if (last) state_n = full == '0 ? DONE : full > WIDTH'(MAX_WORDS) ? ERROR : DATA;
         DATA:    if (last) state_n = WRITE;
         WRITE:   state_n = words_left == WIDTH'(1) ? DONE : DATA;
         default: if (start) state_n = LEN;
      endcase
   end
   always_ff @(posedge clk or negedge rst)
      if (!rst) state <= LEN;
      else      state <= state_n;
   // Header and data bytes share one shift register; the 4th byte completes the word directly.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         byte_cnt   <= '0;
         sr         <= '0;
         words_left <= '0;
         flash_en   <= 1'b0;
         flash_addr <= BASE_ADDR;
         flash_data <= '0;
         cpu_hold   <= 1'b1;
         done       <= 1'b0;
         err        <= 1'b0;
      end else begin
         flash_en <= (state == DATA) & last;
         cpu_hold <= state_n != DONE;
         done     <= state_n == DONE;
         err      <= state_n == ERROR;
         if (xfer) begin
            byte_cnt <= byte_cnt + 2'd1;
            sr       <= {rx_data, sr[23:8]};
         end
         if (state == LEN && last) words_left <= full;
         if (state == DATA && last) flash_data <= full;
         if (state == WRITE) begin
            flash_addr <= flash_addr + WIDTH'(4);
            words_left <= words_left - WIDTH'(1);
         end
         if (rearm) begin
            byte_cnt   <= '0;
            flash_addr <= BASE_ADDR;
         end
      end
   end
endmodule
